// File: rtl/reset_req_gen.sv
// reset_req_gen: board-level reset request generator on the always-on domain.
// Turns a debounced push-button press, a software request level, or a watchdog
// timeout into one fixed-length reset_req pulse and records a sticky cause code.
// This block's own reset must come from the always-on domain, never from
// reset_req_o or anything downstream of it.
//
// Ports:
//   clock_i        single clock
//   reset_i        synchronous, active-high reset
//   button_n_i     raw asynchronous push button, active-low
//   sw_req_i       software reset request, level sampled every cycle
//   wdt_enable_i   watchdog enable
//   wdt_kick_i     watchdog service strobe
//   cause_clear_i  clears the cause register
//   reset_req_o    reset request pulse, active-high, PULSE_CYCLES long
//   cause_o        {wdt, sw, button}, cause of the last accepted request
//   busy_o         high while pulsing or holding off
module reset_req_gen #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned WDT_CYCLES      = 1024,
  parameter int unsigned PULSE_CYCLES    = 4
) (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       button_n_i,
  input  logic       sw_req_i,
  input  logic       wdt_enable_i,
  input  logic       wdt_kick_i,
  input  logic       cause_clear_i,
  output logic       reset_req_o,
  output logic [2:0] cause_o,
  output logic       busy_o
);

  localparam int unsigned DbW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned WdW = $clog2(WDT_CYCLES);
  localparam int unsigned PcW = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;

  localparam logic [DbW-1:0] DbLast = DbW'(DEBOUNCE_CYCLES - 1);
  localparam logic [WdW-1:0] WdLast = WdW'(WDT_CYCLES - 1);
  localparam logic [PcW-1:0] PcLast = PcW'(PULSE_CYCLES - 1);

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StPulse   = 2'd1,
    StHoldoff = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [1:0]     sync_q;
  logic           stable_q, stable_d;
  logic [DbW-1:0] db_cnt_q, db_cnt_d;
  logic [WdW-1:0] wdt_cnt_q, wdt_cnt_d;
  logic [PcW-1:0] pulse_cnt_q, pulse_cnt_d;
  logic [2:0]     cause_q, cause_d;

  logic btn_s;
  logic db_accept;
  logic btn_evt;
  logic sw_evt;
  logic wdt_evt;
  logic in_idle;

  assign btn_s   = sync_q[1];
  assign in_idle = (state_q == StIdle);

  // Two-flop synchronizer; resets to the released (high) level.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], button_n_i};
    end
  end

  // Debounce: a level change is accepted only after DEBOUNCE_CYCLES consecutive
  // mismatching cycles; any return to the stable level restarts the count.
  always_comb begin
    stable_d  = stable_q;
    db_cnt_d  = db_cnt_q;
    db_accept = 1'b0;
    if (btn_s == stable_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_q == DbLast) begin
      stable_d  = btn_s;
      db_cnt_d  = '0;
      db_accept = 1'b1;
    end else begin
      db_cnt_d = db_cnt_q + 1'b1;
    end
  end

  // Only a press (transition to low) is an event; a release is not.
  assign btn_evt = db_accept & ~btn_s;
  assign sw_evt  = sw_req_i;

  // Watchdog: runs only in IDLE while enabled; a kick wins over a timeout.
  assign wdt_evt = in_idle & wdt_enable_i & ~wdt_kick_i & (wdt_cnt_q == WdLast);

  always_comb begin
    wdt_cnt_d = wdt_cnt_q + 1'b1;
    if (!in_idle || !wdt_enable_i || wdt_kick_i || wdt_evt) begin
      wdt_cnt_d = '0;
    end
  end

  // Request FSM next-state, pulse counter and cause register.
  always_comb begin
    state_d     = state_q;
    pulse_cnt_d = pulse_cnt_q;
    cause_d     = cause_q;
    if (cause_clear_i) begin
      cause_d = '0;
    end
    unique case (state_q)
      StIdle: begin
        if (btn_evt || sw_evt || wdt_evt) begin
          state_d     = StPulse;
          pulse_cnt_d = PcLast;
          // Simultaneous sources are all recorded; a new cause beats a clear.
          cause_d     = {wdt_evt, sw_evt, btn_evt};
        end
      end
      StPulse: begin
        if (pulse_cnt_q == '0) begin
          state_d = StHoldoff;
        end else begin
          pulse_cnt_d = pulse_cnt_q - 1'b1;
        end
      end
      StHoldoff: begin
        // Wait for the button to be released and sw_req to drop so a held
        // source cannot immediately re-trigger.
        if (stable_q && !sw_req_i) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      stable_q    <= 1'b1;
      db_cnt_q    <= '0;
      wdt_cnt_q   <= '0;
      pulse_cnt_q <= '0;
      cause_q     <= '0;
      state_q     <= StIdle;
    end else begin
      stable_q    <= stable_d;
      db_cnt_q    <= db_cnt_d;
      wdt_cnt_q   <= wdt_cnt_d;
      pulse_cnt_q <= pulse_cnt_d;
      cause_q     <= cause_d;
      state_q     <= state_d;
    end
  end

  // Outputs decode only the state register, so they cannot glitch on inputs.
  assign reset_req_o = (state_q == StPulse);
  assign busy_o      = (state_q != StIdle);
  assign cause_o     = cause_q;

endmodule

// File: tb/tb_reset_req_gen.sv
// Self-checking bench for reset_req_gen with DEBOUNCE=4, WDT=8, PULSE=4.
module tb_reset_req_gen;

  localparam int D = 4;
  localparam int W = 8;
  localparam int P = 4;

  logic       clock;
  logic       reset;
  logic       button_n;
  logic       sw_req;
  logic       wdt_enable;
  logic       wdt_kick;
  logic       cause_clear;
  logic       reset_req;
  logic [2:0] cause;
  logic       busy;

  int tests = 0;
  int fails = 0;

  // Reference model state, kept as timestamps and run lengths.
  int       cyc = 0;
  bit       m_pipe0 = 1;
  bit       m_pipe1 = 1;
  bit       m_stable = 1;
  int       m_run = 0;
  int       m_wd_origin = 0;
  bit       m_active = 0;
  int       m_pstart = 0;
  bit [2:0] m_cause = 0;
  bit       exp_rr;
  bit       exp_busy;

  reset_req_gen #(
    .DEBOUNCE_CYCLES(D),
    .WDT_CYCLES     (W),
    .PULSE_CYCLES   (P)
  ) dut (
    .clock_i      (clock),
    .reset_i      (reset),
    .button_n_i   (button_n),
    .sw_req_i     (sw_req),
    .wdt_enable_i (wdt_enable),
    .wdt_kick_i   (wdt_kick),
    .cause_clear_i(cause_clear),
    .reset_req_o  (reset_req),
    .cause_o      (cause),
    .busy_o       (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  // Advance the model over the current cycle, clock the DUT, then compare.
  task automatic step();
    bit s, idle, in_pulse, hold, press, fire, st_pre;
    if (reset) begin
      m_pipe0     = 1;
      m_pipe1     = 1;
      m_stable    = 1;
      m_run       = 0;
      m_wd_origin = cyc + 1;
      m_active    = 0;
      m_cause     = 0;
    end else begin
      s        = m_pipe1;
      idle     = !m_active;
      in_pulse = m_active && (cyc < m_pstart + P);
      hold     = m_active && !in_pulse;
      st_pre   = m_stable;
      press    = 0;
      if (s != m_stable) begin
        m_run++;
        if (m_run == D) begin
          m_stable = s;
          m_run    = 0;
          press    = !s;
        end
      end else begin
        m_run = 0;
      end
      fire = idle && wdt_enable && !wdt_kick && (cyc - m_wd_origin == W - 1);
      if (!(idle && wdt_enable) || wdt_kick || fire) m_wd_origin = cyc + 1;
      if (idle && (press || sw_req || fire)) begin
        m_active = 1;
        m_pstart = cyc + 1;
        m_cause  = {fire, sw_req, press};
      end else begin
        if (cause_clear) m_cause = 0;
        if (hold && st_pre && !sw_req) m_active = 0;
      end
      m_pipe1 = m_pipe0;
      m_pipe0 = button_n;
    end
    cyc++;
    @(posedge clock);
    #1;
    exp_rr   = m_active && (cyc < m_pstart + P);
    exp_busy = m_active;
    chk("reset_req", reset_req, exp_rr);
    chk("busy", busy, exp_busy);
    chk("cause", cause, m_cause);
  endtask

  task automatic quiet();
    button_n    = 1;
    sw_req      = 0;
    wdt_enable  = 0;
    wdt_kick    = 0;
    cause_clear = 0;
    reset       = 0;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    logic [5:0] rr_d, rr_m, bz_d;
    int first_d, first_m, cnt;
    int b_dur;
    bit b_lvl;

    quiet();
    reset = 1;
    steps(2);
    chk("rst_reset_req", reset_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cause", cause, 0);
    reset = 0;
    steps(8);

    // Software request: one cycle high.
    sw_req = 1;
    step();
    sw_req = 0;
    rr_d[0] = reset_req; rr_m[0] = exp_rr; bz_d[0] = busy;
    for (int i = 1; i < 6; i++) begin
      step();
      rr_d[i] = reset_req; rr_m[i] = exp_rr; bz_d[i] = busy;
    end
    chk("sw_rr_pattern", rr_d, 6'b001111);
    chk("sw_model_pattern", rr_m, 6'b001111);
    chk("sw_busy_pattern", bz_d, 6'b011111);
    chk("sw_cause", cause, 3'b010);
    steps(3);

    // Button bounce, then a held press.
    button_n = 0;
    steps(3);
    button_n = 1;
    step();
    button_n = 0;
    first_d = -1; cnt = 0;
    for (int j = 0; j < 20; j++) begin
      step();
      if (reset_req && first_d < 0) first_d = j;
      cnt += int'(reset_req);
    end
    chk("btn_first_rise", first_d, 5);
    chk("btn_pulse_len", cnt, 4);
    chk("btn_cause", cause, 3'b001);
    chk("btn_held_busy", busy, 1);
    button_n = 1;
    for (int j = 0; j < 7; j++) begin
      step();
      if (j == 5) chk("btn_release_busy5", busy, 1);
      if (j == 6) chk("btn_release_busy6", busy, 0);
    end
    steps(3);

    // Watchdog timeout with no kicks.
    first_d = -1; first_m = -1; cnt = 0;
    wdt_enable = 1;
    for (int j = 0; j < 12; j++) begin
      step();
      if (reset_req && first_d < 0) first_d = j;
      if (exp_rr && first_m < 0) first_m = j;
      cnt += int'(reset_req);
    end
    chk("wdt_first_rise", first_d, 7);
    chk("wdt_model_rise", first_m, 7);
    chk("wdt_pulse_len", cnt, 4);
    chk("wdt_cause", cause, 3'b100);
    wdt_enable = 0;
    steps(3);

    // Watchdog kept alive by regular kicks.
    cnt = 0;
    for (int j = 0; j < 100; j++) begin
      wdt_enable = 1;
      wdt_kick   = (j % 6 == 0);
      step();
      cnt += int'(reset_req);
    end
    chk("wdt_kicked_no_pulse", cnt, 0);
    wdt_enable = 0;
    wdt_kick   = 0;
    steps(2);

    // Watchdog and sw_req together, then sw_req again mid-pulse.
    first_d = -1; cnt = 0;
    for (int j = 0; j < 15; j++) begin
      wdt_enable = 1;
      sw_req     = (j == 7 || j == 9);
      step();
      if (reset_req && first_d < 0) first_d = j;
      cnt += int'(reset_req);
    end
    chk("sim_first_rise", first_d, 7);
    chk("sim_pulse_len", cnt, 4);
    chk("sim_cause", cause, 3'b110);
    wdt_enable = 0;
    sw_req     = 0;
    steps(3);

    // cause_clear in IDLE.
    cause_clear = 1;
    step();
    cause_clear = 0;
    chk("clear_cause", cause, 0);

    // Reset during the second pulse cycle.
    sw_req = 1;
    step();
    sw_req = 0;
    step();
    chk("mid_pulse_rr", reset_req, 1);
    reset = 1;
    step();
    reset = 0;
    chk("rst_mid_rr", reset_req, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_cause", cause, 0);
    steps(3);
    sw_req = 1;
    step();
    sw_req = 0;
    chk("after_rst_rr", reset_req, 1);
    chk("after_rst_cause", cause, 3'b010);
    steps(6);

    // Randomized traffic, checked every cycle against the model.
    b_lvl = 1;
    b_dur = 0;
    for (int j = 0; j < 4000; j++) begin
      if (b_dur == 0) begin
        b_lvl = ~b_lvl;
        b_dur = ($urandom_range(0, 3) == 0) ? $urandom_range(5, 30) : $urandom_range(1, 5);
      end
      b_dur--;
      button_n    = b_lvl;
      sw_req      = ($urandom_range(0, 49) == 0);
      if (j % 200 == 0) wdt_enable = $urandom_range(0, 1) == 1;
      wdt_kick    = ($urandom_range(0, 9) == 0);
      cause_clear = ($urandom_range(0, 39) == 0);
      reset       = ($urandom_range(0, 499) == 0);
      step();
    end
    quiet();
    steps(4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
